// File: rtl/fp_divider_seq.sv
// Iterative FP32 divider (Z = X / Y): restoring division, one quotient bit per clock,
// fixed 29-cycle latency from the start edge to the done pulse for every operand class.
module fp_divider_seq (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic        Sx,
    input  logic        Sy,
    input  logic [7:0]  Ex,
    input  logic [7:0]  Ey,
    input  logic [22:0] Mx,
    input  logic [22:0] My,
    input  logic [1:0]  R_mode,
    output logic        busy,
    output logic        done,
    output logic        Sz,
    output logic [7:0]  Ez,
    output logic [22:0] Mz,
    output logic        invalid_flag,
    output logic        divzero_flag,
    output logic        overflow_flag,
    output logic        underflow_flag,
    output logic        inexact_flag,
    output logic        zero_flag,
    output logic [2:0]  dbg_state
);
    // start is only honoured in IDLE; busy = any non-IDLE state, done = the single DONE cycle.
    typedef enum logic [2:0] {IDLE, LOAD, DIVIDE, ROUND, DONE} state_t;
    typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_t;

    state_t             r_state, w_next;
    special_t           r_special;
    logic               r_divz;
    logic               r_sign;
    logic [1:0]         r_rmode;
    logic [7:0]         r_ex, r_ey;
    logic [22:0]        r_mx, r_my;
    logic signed [9:0]  r_eq;
    logic [25:0]        r_rem;
    logic [23:0]        r_div;
    logic [25:0]        r_q;
    logic [4:0]         r_cnt;
    logic               r_sz_o;
    logic [7:0]         r_ez_o;
    logic [22:0]        r_mz_o;
    logic [5:0]         r_flags_o;

    logic               w_x_zero, w_x_inf, w_x_nan, w_y_zero, w_y_inf, w_y_nan;
    logic               w_ge;
    logic [25:0]        w_trial;
    logic               w_norm, w_guard, w_sticky, w_inc, w_to_inf;
    logic [22:0]        w_frac;
    logic [23:0]        w_fsum;
    logic signed [9:0]  w_exp;
    logic               w_res_s;
    logic [7:0]         w_res_e;
    logic [22:0]        w_res_m;
    logic [5:0]         w_res_flags;

    assign w_x_zero = (r_ex == 8'd0);
    assign w_x_inf  = (r_ex == 8'hFF) && (r_mx == 23'd0);
    assign w_x_nan  = (r_ex == 8'hFF) && (r_mx != 23'd0);
    assign w_y_zero = (r_ey == 8'd0);
    assign w_y_inf  = (r_ey == 8'hFF) && (r_my == 23'd0);
    assign w_y_nan  = (r_ey == 8'hFF) && (r_my != 23'd0);

    assign w_ge    = (r_rem >= {2'b00, r_div});
    assign w_trial = r_rem - {2'b00, r_div};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = LOAD;
            LOAD:    w_next = DIVIDE;
            DIVIDE:  if (r_cnt == 5'd0) w_next = ROUND;
            ROUND:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Rounding and range handling; the hidden bit is always set, so a fraction carry is a mantissa carry.
    always_comb begin
        w_norm   = r_q[25];
        w_frac   = w_norm ? r_q[24:2] : r_q[23:1];
        w_guard  = w_norm ? r_q[1] : r_q[0];
        w_sticky = (w_norm & r_q[0]) | (r_rem != 26'd0);
        case (r_rmode)
            2'b00:   w_inc = w_guard & (w_sticky | w_frac[0]);
            2'b10:   w_inc = (w_guard | w_sticky) & ~r_sign;
            2'b11:   w_inc = (w_guard | w_sticky) & r_sign;
            default: w_inc = 1'b0;
        endcase
        w_fsum   = {1'b0, w_frac} + {23'd0, w_inc};
        w_exp    = r_eq - (w_norm ? 10'sd0 : 10'sd1) + (w_fsum[23] ? 10'sd1 : 10'sd0);
        w_to_inf = (r_rmode == 2'b00) | ((r_rmode == 2'b10) & ~r_sign) | ((r_rmode == 2'b11) & r_sign);

        w_res_s     = r_sign;
        w_res_e     = w_exp[7:0];
        w_res_m     = w_fsum[22:0];
        w_res_flags = {4'b0000, w_guard | w_sticky, 1'b0};
        case (r_special)
            SP_NAN: begin
                w_res_s     = 1'b0;
                w_res_e     = 8'hFF;
                w_res_m     = 23'h400000;
                w_res_flags = 6'b100000;
            end
            SP_INF: begin
                w_res_e     = 8'hFF;
                w_res_m     = 23'd0;
                w_res_flags = {1'b0, r_divz, 4'b0000};
            end
            SP_ZERO: begin
                w_res_e     = 8'd0;
                w_res_m     = 23'd0;
                w_res_flags = 6'b000001;
            end
            default: begin
                if (w_exp >= 10'sd255) begin
                    w_res_e     = w_to_inf ? 8'hFF : 8'hFE;
                    w_res_m     = w_to_inf ? 23'd0 : 23'h7FFFFF;
                    w_res_flags = 6'b001010;
                end else if (w_exp <= 10'sd0) begin
                    w_res_e     = 8'd0;
                    w_res_m     = 23'd0;
                    w_res_flags = 6'b000111;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_special <= SP_NONE;
            r_divz    <= 1'b0;
            r_sign    <= 1'b0;
            r_rmode   <= 2'b00;
            r_ex      <= 8'd0;
            r_ey      <= 8'd0;
            r_mx      <= 23'd0;
            r_my      <= 23'd0;
            r_eq      <= 10'sd0;
            r_rem     <= 26'd0;
            r_div     <= 24'd0;
            r_q       <= 26'd0;
            r_cnt     <= 5'd0;
            r_sz_o    <= 1'b0;
            r_ez_o    <= 8'd0;
            r_mz_o    <= 23'd0;
            r_flags_o <= 6'd0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_sign  <= Sx ^ Sy;
                    r_rmode <= R_mode;
                    r_ex    <= Ex;
                    r_ey    <= Ey;
                    r_mx    <= Mx;
                    r_my    <= My;
                end
                LOAD: begin
                    r_divz <= 1'b0;
                    if (w_x_nan | w_y_nan | (w_x_zero & w_y_zero) | (w_x_inf & w_y_inf))
                        r_special <= SP_NAN;
                    else if (w_x_inf)
                        r_special <= SP_INF;
                    else if (w_y_zero) begin
                        r_special <= SP_INF;
                        r_divz    <= 1'b1;
                    end else if (w_x_zero | w_y_inf)
                        r_special <= SP_ZERO;
                    else
                        r_special <= SP_NONE;
                    r_eq  <= $signed({2'b00, r_ex}) - $signed({2'b00, r_ey}) + 10'sd127;
                    r_rem <= {3'b001, r_mx};
                    r_div <= {1'b1, r_my};
                    r_q   <= 26'd0;
                    r_cnt <= 5'd25;
                end
                DIVIDE: begin
                    r_rem <= (w_ge ? w_trial : r_rem) << 1;
                    r_q   <= {r_q[24:0], w_ge};
                    r_cnt <= r_cnt - 5'd1;
                end
                ROUND: begin
                    r_sz_o    <= w_res_s;
                    r_ez_o    <= w_res_e;
                    r_mz_o    <= w_res_m;
                    r_flags_o <= w_res_flags;
                end
                default: ;
            endcase
        end
    end

    assign busy           = (r_state != IDLE);
    assign done           = (r_state == DONE);
    assign Sz             = r_sz_o;
    assign Ez             = r_ez_o;
    assign Mz             = r_mz_o;
    assign invalid_flag   = r_flags_o[5];
    assign divzero_flag   = r_flags_o[4];
    assign overflow_flag  = r_flags_o[3];
    assign underflow_flag = r_flags_o[2];
    assign inexact_flag   = r_flags_o[1];
    assign zero_flag      = r_flags_o[0];
    assign dbg_state      = r_state;

endmodule

// File: doc/fp_divider_seq.md
# fp_divider_seq

Iterative single-precision IEEE-754 divider computing Z = X / Y, one quotient bit per clock. It is the inverse-operation companion to the pipelined multiplier in the FPU datapath and uses the same split sign/exponent/mantissa operand format, rounding-mode encoding and exception flag set. It is driven by the FPU issue logic through a start/busy/done handshake and has a fixed latency.

## Interface
- No parameters; operand format fixed at FP32 (1/8/23).
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- start  in  1  request; operands and R_mode sampled on the same edge when IDLE.
- Sx, Sy  in  1  dividend / divisor sign.
- Ex, Ey  in  8  biased exponents.
- Mx, My  in  23  stored fractions (hidden bit implied).
- R_mode  in  2  00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf.
- busy  out  1  high while a division is in flight.
- done  out  1  one-cycle pulse; result and flags valid.
- Sz, Ez, Mz  out  1/8/23  result fields; held until the next done.
- invalid_flag, divzero_flag, overflow_flag, underflow_flag, inexact_flag, zero_flag  out  1 each  exception flags; held with the result.

## Operation
- FSM states: IDLE, LOAD, DIVIDE, ROUND, DONE.
- IDLE: start=1 latches the operands, R_mode and Sz=Sx^Sy, then moves to LOAD. start is ignored in all other states.
- LOAD (1 cycle):
  - Classify operands. E=0 is zero (denormals flushed to zero). E=255 with M=0 is inf; E=255 with M≠0 is NaN.
  - Compute 10-bit signed Eq = Ex − Ey + 127.
  - Load dividend 1.Mx and divisor 1.My (24 bits each), clear quotient, set bit counter to 25.
- DIVIDE (26 cycles): restoring division. Per cycle, trial-subtract the divisor from the remainder, shift in quotient bit q[k], then shift the remainder left. The counter decrements; exit to ROUND when it reaches 0.
- ROUND (1 cycle):
  - Normalize:
    - If q[25]=1: mantissa = q[25:2], guard = q[1], sticky = q[0] | (rem≠0).
    - Otherwise: mantissa = q[24:1], guard = q[0], sticky = (rem≠0), and Eq−1.
  - Round per R_mode:
    - Nearest-even: increment if guard & (sticky | lsb).
    - +inf: increment if (guard|sticky) & ~Sz.
    - −inf: increment if (guard|sticky) & Sz.
    - Toward zero: never increment.
  - Mantissa carry-out sets mantissa = 1.0 and Eq+1.
  - inexact = guard | sticky.
- Range:
  - Eq ≥ 255 → overflow_flag=1, inexact_flag=1. Result is ±inf under nearest-even and under a directed mode toward the sign. Under toward-zero, or a directed mode against the sign, result is the max finite value (E=254, M=0x7FFFFF).
  - Eq ≤ 0 → signed zero, underflow_flag=1, inexact_flag=1, zero_flag=1.
- Specials: decided in LOAD, but the FSM still runs the full latency.
  - Any NaN, 0/0, or inf/inf → quiet NaN (S=0, E=255, M=0x400000), invalid_flag=1.
  - Finite nonzero / 0 → signed inf, divzero_flag=1.
  - inf / finite → signed inf, no flag.
  - 0 / nonzero, or finite / inf → signed zero, zero_flag=1.
- DONE (1 cycle): register result and flags, pulse done, return to IDLE.

## Timing
- Reset: FSM to IDLE. busy, done, Sz, Ez, Mz and all flags are 0. An in-flight division is discarded and produces no done.
- start accepted at edge T:
  - busy=1 from T+1 through T+29.
  - LOAD at T+1, DIVIDE T+2..T+27, ROUND T+28, DONE T+29.
  - done=1 during cycle T+29 only.
- Fixed latency of 29 cycles for all operand classes, including specials.
- start may be reasserted in the cycle after done (back-to-back issue every 30 cycles).
- Outputs change only on the done edge. Inputs need not be held after the start edge.

## Test plan
- 6.0/2.0 (Ex=129, Mx=0x400000; Ey=128, My=0), R_mode=00 → done at T+29, Sz=0, Ez=128, Mz=0x400000, all flags 0.
- 1.0/3.0 (Ex=127, Mx=0; Ey=128, My=0x400000):
  - R_mode=00 → Ez=125, Mz=0x2AAAAB, inexact_flag=1.
  - R_mode=01 → Mz=0x2AAAAA.
- 5.0/+0 → Sz=0, Ez=255, Mz=0, divzero_flag=1. Also 0/0 → Ez=255, Mz=0x400000, invalid_flag=1.
- Max finite / 0.5 (Ex=254, Mx=0x7FFFFF; Ey=126, My=0):
  - R_mode=00 → +inf, overflow_flag=1.
  - R_mode=01 → Ez=254, Mz=0x7FFFFF.
- 2^-126 / 2.0 (Ex=1; Ey=128) → Ez=0, Mz=0, underflow_flag=1, zero_flag=1.
- Reset and busy:
  - Assert RST low at T+10 → busy=0 immediately, no done.
  - start at T+5 during a division is ignored; the first result still arrives at T+29.
